// File: rtl/swd_xfer_seq.sv
// Transfer sequencer between the command layer and the swdIF line engine (go/idle handshake).
// Build option: define SWD_POSTED_AP_READ_EN to pipeline AP reads through a single trailing RDBUFF.
module swd_xfer_seq #(
    parameter int WAIT_RETRY = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_apndp,
    input  logic        cmd_rnw,
    input  logic [1:0]  cmd_addr32,
    input  logic [31:0] cmd_wdata,
    input  logic [7:0]  cmd_count,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_ack,
    output logic        rsp_perr,
    output logic        rsp_last,
    output logic        if_go,
    output logic [1:0]  if_addr32,
    output logic        if_rnw,
    output logic        if_apndp,
    output logic [31:0] if_dwrite,
    input  logic        if_idle,
    input  logic [2:0]  if_ack,
    input  logic [31:0] if_dread,
    input  logic        if_perr
);
`ifdef SWD_POSTED_AP_READ_EN
    localparam logic POSTED = 1'b1;
`else
    localparam logic POSTED = 1'b0;
`endif
    localparam logic [2:0] ACK_OK   = 3'b001;
    localparam logic [2:0] ACK_WAIT = 3'b010;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_EVAL, S_RSP} state_t;

    state_t      state_q, state_d;
    logic        c_apndp_q, c_apndp_d, c_rnw_q, c_rnw_d;
    logic [1:0]  c_addr_q, c_addr_d;
    logic [31:0] c_wdata_q, c_wdata_d;
    logic [7:0]  rem_q, rem_d;
    logic [15:0] waitcnt_q, waitcnt_d;
    logic        pend_q, pend_d, rdbuf_q, rdbuf_d, go_q, go_d;
    logic        f_apndp_q, f_apndp_d, f_rnw_q, f_rnw_d;
    logic [1:0]  f_addr_q, f_addr_d;
    logic [31:0] f_dwrite_q, f_dwrite_d;
    logic        rv_q, rv_d, rp_q, rp_d, rl_q, rl_d;
    logic [31:0] rd_q, rd_d;
    logic [2:0]  ra_q, ra_d;
    logic        acc_s, ld_s, ld_rdbuf_s, rsp_s, rsp_perr_s, rsp_last_s, apr_s;
    logic [31:0] rsp_data_s;
    logic [2:0]  rsp_ack_s;

    assign apr_s     = c_apndp_q & c_rnw_q;
    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = rv_q;
    assign rsp_data  = rd_q;
    assign rsp_ack   = ra_q;
    assign rsp_perr  = rp_q;
    assign rsp_last  = rl_q;
    assign if_go     = go_q;
    assign if_addr32 = f_addr_q;
    assign if_rnw    = f_rnw_q;
    assign if_apndp  = f_apndp_q;
    assign if_dwrite = f_dwrite_q;

    always_comb begin
        state_d = state_q;  c_apndp_d = c_apndp_q;  c_rnw_d = c_rnw_q;
        c_addr_d = c_addr_q;  c_wdata_d = c_wdata_q;  rem_d = rem_q;
        waitcnt_d = waitcnt_q;  pend_d = pend_q;  rdbuf_d = rdbuf_q;  go_d = 1'b0;
        f_apndp_d = f_apndp_q;  f_rnw_d = f_rnw_q;  f_addr_d = f_addr_q;  f_dwrite_d = f_dwrite_q;
        rv_d = rv_q;  rd_d = rd_q;  ra_d = ra_q;  rp_d = rp_q;  rl_d = rl_q;
        acc_s = 1'b0;  ld_s = 1'b0;  ld_rdbuf_s = 1'b0;  rsp_s = 1'b0;
        rsp_data_s = 32'd0;  rsp_ack_s = 3'd0;  rsp_perr_s = 1'b0;  rsp_last_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    acc_s = 1'b1;
                    c_apndp_d = cmd_apndp;  c_rnw_d = cmd_rnw;
                    c_addr_d = cmd_addr32;  c_wdata_d = cmd_wdata;
                    rem_d = (cmd_count == 8'd0) ? 8'd1 : cmd_count;
                    waitcnt_d = 16'd0;  pend_d = 1'b0;
                    go_d = if_idle;  state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            // go is raised only once swdIF is idle and dropped after idle is seen low
            S_ISSUE: begin
                if (go_q && !if_idle) begin
                    go_d = 1'b0;  state_d = S_BUSY;
                end else begin
                    go_d = go_q | if_idle;
                end
            end
            S_BUSY: begin
                if (if_idle) begin
                    state_d = S_EVAL;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_EVAL: begin
                if (if_ack == ACK_OK) begin
                    waitcnt_d = 16'd0;
                    if (f_rnw_q && if_perr) begin
                        rsp_s = 1'b1;  rsp_ack_s = ACK_OK;  rsp_data_s = if_dread;
                        rsp_perr_s = 1'b1;  rsp_last_s = 1'b1;
                    end else if (apr_s && !rdbuf_q) begin
                        // AP read data is posted: posted build streams, plain build fetches RDBUFF now
                        if (POSTED && pend_q) begin
                            rem_d = rem_q - 8'd1;
                            rsp_s = 1'b1;  rsp_ack_s = ACK_OK;  rsp_data_s = if_dread;
                        end else if (POSTED) begin
                            rem_d = rem_q - 8'd1;  pend_d = 1'b1;
                            ld_s = 1'b1;  ld_rdbuf_s = (rem_q == 8'd1);
                            go_d = if_idle;  state_d = S_ISSUE;
                        end else begin
                            ld_s = 1'b1;  ld_rdbuf_s = 1'b1;
                            go_d = if_idle;  state_d = S_ISSUE;
                        end
                    end else if (POSTED && rdbuf_q) begin
                        pend_d = 1'b0;
                        rsp_s = 1'b1;  rsp_ack_s = ACK_OK;  rsp_data_s = if_dread;  rsp_last_s = 1'b1;
                    end else begin
                        rem_d = rem_q - 8'd1;
                        rsp_s = 1'b1;  rsp_ack_s = ACK_OK;
                        rsp_data_s = f_rnw_q ? if_dread : 32'd0;
                        rsp_last_s = (rem_q == 8'd1);
                    end
                end else if ((if_ack == ACK_WAIT) && (waitcnt_q < 16'(WAIT_RETRY))) begin
                    waitcnt_d = waitcnt_q + 16'd1;
                    go_d = if_idle;  state_d = S_ISSUE;
                end else begin
                    rsp_s = 1'b1;  rsp_ack_s = if_ack;  rsp_last_s = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rv_d = 1'b0;
                    if (rl_q) begin
                        state_d = S_IDLE;
                    end else begin
                        // not last with nothing remaining means only the RDBUFF fetch is left
                        ld_s = 1'b1;  ld_rdbuf_s = (rem_q == 8'd0);
                        go_d = if_idle;  state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_RSP;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rsp_s) begin
            state_d = S_RSP;  rv_d = 1'b1;  rd_d = rsp_data_s;
            ra_d = rsp_ack_s;  rp_d = rsp_perr_s;  rl_d = rsp_last_s;
        end else begin
            rd_d = rd_q;
        end
        if (acc_s) begin
            rdbuf_d = 1'b0;  f_apndp_d = cmd_apndp;  f_rnw_d = cmd_rnw;
            f_addr_d = cmd_addr32;  f_dwrite_d = cmd_wdata;
        end else if (ld_s) begin
            rdbuf_d    = ld_rdbuf_s;
            f_apndp_d  = ld_rdbuf_s ? 1'b0 : c_apndp_q;
            f_rnw_d    = ld_rdbuf_s ? 1'b1 : c_rnw_q;
            f_addr_d   = ld_rdbuf_s ? 2'b11 : c_addr_q;
            f_dwrite_d = ld_rdbuf_s ? 32'd0 : c_wdata_q;
        end else begin
            rdbuf_d = rdbuf_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;  c_apndp_q <= 1'b0;  c_rnw_q <= 1'b0;  c_addr_q <= 2'd0;
            c_wdata_q <= 32'd0;  rem_q <= 8'd0;  waitcnt_q <= 16'd0;  pend_q <= 1'b0;
            rdbuf_q <= 1'b0;  go_q <= 1'b0;  f_apndp_q <= 1'b0;  f_rnw_q <= 1'b0;
            f_addr_q <= 2'd0;  f_dwrite_q <= 32'd0;  rv_q <= 1'b0;  rd_q <= 32'd0;
            ra_q <= 3'd0;  rp_q <= 1'b0;  rl_q <= 1'b0;
        end else begin
            state_q <= state_d;  c_apndp_q <= c_apndp_d;  c_rnw_q <= c_rnw_d;  c_addr_q <= c_addr_d;
            c_wdata_q <= c_wdata_d;  rem_q <= rem_d;  waitcnt_q <= waitcnt_d;  pend_q <= pend_d;
            rdbuf_q <= rdbuf_d;  go_q <= go_d;  f_apndp_q <= f_apndp_d;  f_rnw_q <= f_rnw_d;
            f_addr_q <= f_addr_d;  f_dwrite_q <= f_dwrite_d;  rv_q <= rv_d;  rd_q <= rd_d;
            ra_q <= ra_d;  rp_q <= rp_d;  rl_q <= rl_d;
        end
    end
endmodule

// File: doc/swd_xfer_seq.md
# swd_xfer_seq

Transfer sequencer that sits between the command/packet layer and the `swdIF` SWD line engine. It accepts single or repeated DP/AP transfer commands and drives `swdIF`'s go/idle handshake, one transfer at a time. It handles WAIT retries, FAULT/protocol/parity aborts and AP read posting via DP RDBUFF, and returns one response per data word.

## Interface
- `WAIT_RETRY`, default 100: max reissues of a transfer answered with WAIT (16-bit counter).
- `clk` input 1: system clock, same domain as `swdIF`.
- `rst` input 1: reset, synchronous, active-high.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: command accepted when `cmd_valid` and `cmd_ready` are both high on a `clk` edge.
- `cmd_apndp`, `cmd_rnw` input 1 each: AP(1)/DP(0); read(1)/write(0).
- `cmd_addr32` input 2: address bits 3:2.
- `cmd_wdata` input 32: write data, reused for every repeat.
- `cmd_count` input 8: repeat count; 0 is treated as 1.
- `rsp_valid` output 1, `rsp_ready` input 1: response handshake.
- `rsp_data` output 32: read data (0 for writes).
- `rsp_ack` output 3: ack of the transfer that produced this word.
- `rsp_perr` output 1: read parity error.
- `rsp_last` output 1: final response of the command, either normal or abort.
- `if_go`, `if_addr32[1:0]`, `if_rnw`, `if_apndp`, `if_dwrite[31:0]` outputs: drive `swdIF` `go`/`addr32`/`rnw`/`apndp`/`dwrite`.
- `if_idle`, `if_ack[2:0]`, `if_dread[31:0]`, `if_perr` inputs: from `swdIF` `idle`/`ack`/`dread`/`perr`.

## Operation
- States:
  - S_IDLE
  - S_ISSUE: `if_go`=1, waiting for `if_idle`=0.
  - S_BUSY: waiting for `if_idle`=1.
  - S_EVAL
  - S_RSP: `rsp_valid`=1 until `rsp_ready`.
- `cmd_ready` = (state==S_IDLE) && !`rst`. On accept:
  - latch all cmd fields;
  - set remaining = max(`cmd_count`,1);
  - set waitcnt=0;
  - go to S_ISSUE.
- `if_addr32`/`if_rnw`/`if_apndp`/`if_dwrite` come from registers. They are stable from S_ISSUE entry until S_BUSY exit, because `swdIF` reads them continuously during the frame.
- `if_go` is held high in S_ISSUE only. It drops on the cycle after `if_idle` is seen low, because `swdIF` samples go only on its `rising` strobe.
- S_EVAL classifies `if_ack`:
  - 001 OK:
    - if `if_rnw` && `if_perr`, treat as error;
    - else produce the response (see posting rules), decrement remaining, reset waitcnt;
    - if remaining is now 0 (and no RDBUFF is pending), set `rsp_last`=1.
  - 010 WAIT: if waitcnt<`WAIT_RETRY`, increment waitcnt and go back to S_ISSUE with no response. Otherwise respond with ack=010 and `rsp_last`=1.
  - 100 FAULT, or any other value: respond with that ack and `rsp_last`=1; the remaining count is discarded.
- A read with a parity error responds with ack=001, `rsp_perr`=1, `rsp_last`=1.
- Write responses carry `rsp_data`=0.
- After S_RSP completes: go to S_ISSUE if work remains, else S_IDLE.
- Remaining-count arithmetic is 8-bit; it never wraps because the 0→1 substitution happens at accept.
- A `rst` mid-frame returns to S_IDLE immediately with `if_go`=0. `swdIF` shares the same `rst`, so both are idle together.

## Timing
- Reset values: `cmd_ready`=0 while `rst`=1 (1 on the first cycle after release), `rsp_valid`=0, `rsp_*`=0, `if_go`=0, `if_*` drive registers=0.
- Accept→`if_go` high: 1 cycle.
- `if_idle` high seen in S_BUSY → S_EVAL: 1 cycle. S_EVAL → `rsp_valid`: 1 cycle. So the response appears 2 cycles after `swdIF` returns to idle.
- While `rsp_valid`=1 and `rsp_ready`=0, all response outputs hold and no new transfer is issued (backpressure stalls the link).
- `rsp_valid` deasserts on the cycle after the handshake.
- `if_go` never asserts while `if_idle`=0 at S_ISSUE entry; the block waits for idle first.

## Configuration
- Macro: `SWD_POSTED_AP_READ_EN`.
- Defined: AP reads of a command are pipelined.
  - The first AP read's ack is checked but its data is not returned.
  - Each subsequent AP read returns the previous word.
  - After the last AP read, a DP RDBUFF read (`apndp`=0, `addr32`=2'b11, `rnw`=1) fetches the final word and carries `rsp_last`.
  - A WAIT/FAULT on any transfer aborts with no RDBUFF.
  - N AP reads cost N+1 frames.
- Undefined: every AP read is immediately followed by its own RDBUFF read. The response for that word comes from the RDBUFF frame, so N AP reads cost 2N frames.
- DP reads and all writes behave identically in both builds.

## Test plan
- DP read `addr32`=2'b00, count=1, target acks 001, data 0x2BA01477 → one response: data 0x2BA01477, ack 001, perr 0, last 1; exactly one go pulse.
- AP write, count=3, data 0xDEADBEEF, all acks 001 → three `swdIF` frames each with `if_dwrite`=0xDEADBEEF; three responses with last on the third.
- DP read answered WAIT twice then OK, `WAIT_RETRY`=100 → three frames, one response with ack 001; with `WAIT_RETRY`=1 → two frames, response ack 010, last 1.
- AP read, count=4, second transfer acks 100 → responses stop with ack 100 and last 1; no further frames and no RDBUFF.
- AP read, count=3, data words 0x11/0x22/0x33:
  - macro on: 4 frames, the last being RDBUFF; responses 0x11, 0x22, 0x33.
  - macro off: 6 frames, same responses.
- `rsp_ready` held low for 20 cycles during count=2 read → `rsp_*` stable and no `if_go` issued until accept. Separately, assert `rst` mid-frame → `if_go`=0, `rsp_valid`=0, `cmd_ready`=1 one cycle after release.
